// File: rtl/if_stage.sv
// Instruction-fetch stage: fetch PC, synchronous instruction SRAM interface, IC register and skid buffer.
// Optional issued-fetch counter built only when IF_PERF_CNT_EN is defined.
module if_stage #(
    parameter logic [31:0] RESET_PC = 32'hBFC0_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [5:0]  stall,
    input  logic        flush,
    input  logic [31:0] new_pc,
    input  logic        br_e,
    input  logic [31:0] br_addr,
    output logic        inst_sram_en,
    output logic [31:0] inst_sram_addr,
    input  logic [31:0] inst_sram_rdata,
    output logic [32:0] ic_to_id_bus,
    output logic [31:0] ic_inst,
    output logic [31:0] fetch_cnt
);

    logic [31:0] pc_q,        pc_d;
    logic [31:0] ic_pc_q,     ic_pc_d;
    logic        ic_valid_q,  ic_valid_d;
    logic [31:0] inst_buf_q,  inst_buf_d;
    logic        buf_valid_q, buf_valid_d;
    logic        redirect;

    // Only the PC and IC stall bits matter here; the rest of the StallBus is for later stages.
    logic unused_stall_bits;
    assign unused_stall_bits = ^stall[5:3];

    assign redirect       = flush | br_e;
    assign inst_sram_en   = rst & ~stall[0];
    assign inst_sram_addr = pc_q;

    // NOTE: every always_comb target gets a default first, so no path can infer a latch.
    always_comb begin
        pc_d = pc_q;
        if (flush)          pc_d = new_pc;
        else if (br_e)      pc_d = br_addr;
        else if (!stall[0]) pc_d = pc_q + 32'd4;
    end

    always_comb begin
        ic_pc_d    = ic_pc_q;
        ic_valid_d = ic_valid_q;
        if (redirect || (stall[1] && !stall[2])) begin
            ic_pc_d    = '0;
            ic_valid_d = 1'b0;
        end else if (!stall[1]) begin
            ic_pc_d    = pc_q;
            ic_valid_d = inst_sram_en;
        end
    end

    // Data returning while IC is stopped is parked here so it is never re-fetched.
    always_comb begin
        inst_buf_d  = inst_buf_q;
        buf_valid_d = buf_valid_q;
        if (redirect || !stall[1]) begin
            buf_valid_d = 1'b0;
        end else if (ic_valid_q && !buf_valid_q) begin
            inst_buf_d  = inst_sram_rdata;
            buf_valid_d = 1'b1;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together at the edge.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pc_q        <= RESET_PC;
            ic_pc_q     <= '0;
            ic_valid_q  <= 1'b0;
            inst_buf_q  <= '0;
            buf_valid_q <= 1'b0;
        end else begin
            pc_q        <= pc_d;
            ic_pc_q     <= ic_pc_d;
            ic_valid_q  <= ic_valid_d;
            inst_buf_q  <= inst_buf_d;
            buf_valid_q <= buf_valid_d;
        end
    end

    assign ic_to_id_bus = {ic_valid_q, ic_pc_q};
    assign ic_inst      = buf_valid_q ? inst_buf_q
                        : (ic_valid_q ? inst_sram_rdata : 32'd0);

`ifdef IF_PERF_CNT_EN
    logic [31:0] fetch_cnt_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)              fetch_cnt_q <= '0;
        else if (inst_sram_en) fetch_cnt_q <= fetch_cnt_q + 32'd1;
    end

    assign fetch_cnt = fetch_cnt_q;
`else
    assign fetch_cnt = 32'd0;
`endif

endmodule

// File: tb/tb_if_stage.sv
// Self-checking bench for if_stage: table of per-cycle vectors through a scoreboard queue,
// plus hand-written reset-during-stall and fetch counter sequences.
module tb_if_stage;

    typedef struct {
        logic [5:0]  stall;
        logic        flush;
        logic [31:0] new_pc;
        logic        br_e;
        logic [31:0] br_addr;
        logic [31:0] rdata;
        logic        exp_en;
        logic [31:0] exp_addr;
        logic [32:0] exp_bus;
        logic [31:0] exp_inst;
    } vec_t;

    logic        clk;
    logic        rst;
    logic [5:0]  stall;
    logic        flush;
    logic [31:0] new_pc;
    logic        br_e;
    logic [31:0] br_addr;
    logic        inst_sram_en;
    logic [31:0] inst_sram_addr;
    logic [31:0] inst_sram_rdata;
    logic [32:0] ic_to_id_bus;
    logic [31:0] ic_inst;
    logic [31:0] fetch_cnt;

    int checks;
    int failures;

    vec_t vecs[$];
    vec_t exp_q[$];

    if_stage dut (
        .clk             (clk),
        .rst             (rst),
        .stall           (stall),
        .flush           (flush),
        .new_pc          (new_pc),
        .br_e            (br_e),
        .br_addr         (br_addr),
        .inst_sram_en    (inst_sram_en),
        .inst_sram_addr  (inst_sram_addr),
        .inst_sram_rdata (inst_sram_rdata),
        .ic_to_id_bus    (ic_to_id_bus),
        .ic_inst         (ic_inst),
        .fetch_cnt       (fetch_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [32:0] actual, input logic [32:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, actual, expected);
        end
    endtask

    function automatic vec_t mk(input logic [5:0] s, input logic fl, input logic [31:0] np,
                                input logic be, input logic [31:0] ba, input logic [31:0] rd,
                                input logic en, input logic [31:0] addr, input logic [32:0] bus,
                                input logic [31:0] inst);
        vec_t v;
        v.stall = s;   v.flush = fl;  v.new_pc = np;  v.br_e = be;  v.br_addr = ba;
        v.rdata = rd;  v.exp_en = en; v.exp_addr = addr; v.exp_bus = bus; v.exp_inst = inst;
        return v;
    endfunction

    initial begin
        vec_t e;
        logic [31:0] exp_cnt;
        checks = 0;
        failures = 0;
        rst = 1'b0; stall = '0; flush = 1'b0; new_pc = '0; br_e = 1'b0; br_addr = '0;
        inst_sram_rdata = '0;

        // stall, flush, new_pc, br_e, br_addr, rdata | en, addr, bus, inst
        vecs.push_back(mk(6'd0, 0, 0, 0, 0, 32'h0000_0000, 1, 32'hBFC0_0000, 33'h0,           32'h0));
        vecs.push_back(mk(6'd0, 0, 0, 0, 0, 32'h3C08_BFC0, 1, 32'hBFC0_0004, 33'h1_BFC0_0000, 32'h3C08_BFC0));
        vecs.push_back(mk(6'd3, 0, 0, 0, 0, 32'h2408_0001, 0, 32'hBFC0_0008, 33'h1_BFC0_0004, 32'h2408_0001));
        vecs.push_back(mk(6'd3, 0, 0, 0, 0, 32'hDEAD_BEEF, 0, 32'hBFC0_0008, 33'h0,           32'h2408_0001));
        vecs.push_back(mk(6'd3, 0, 0, 0, 0, 32'hDEAD_BEEF, 0, 32'hBFC0_0008, 33'h0,           32'h2408_0001));
        vecs.push_back(mk(6'd0, 0, 0, 0, 0, 32'hDEAD_BEEF, 1, 32'hBFC0_0008, 33'h0,           32'h2408_0001));
        vecs.push_back(mk(6'd0, 0, 0, 0, 0, 32'h2409_0002, 1, 32'hBFC0_000C, 33'h1_BFC0_0008, 32'h2409_0002));
        vecs.push_back(mk(6'd0, 0, 0, 1, 32'h8000_0100, 32'h0109_5020, 1, 32'hBFC0_0010, 33'h1_BFC0_000C, 32'h0109_5020));
        vecs.push_back(mk(6'd0, 0, 0, 0, 0, 32'h1111_1111, 1, 32'h8000_0100, 33'h0,           32'h0));
        vecs.push_back(mk(6'd0, 0, 0, 0, 0, 32'h8C02_0000, 1, 32'h8000_0104, 33'h1_8000_0100, 32'h8C02_0000));
        vecs.push_back(mk(6'd7, 0, 0, 0, 0, 32'h0000_0021, 0, 32'h8000_0108, 33'h1_8000_0104, 32'h0000_0021));
        vecs.push_back(mk(6'd7, 0, 0, 0, 0, 32'hCAFE_F00D, 0, 32'h8000_0108, 33'h1_8000_0104, 32'h0000_0021));
        vecs.push_back(mk(6'd0, 0, 0, 0, 0, 32'hCAFE_F00D, 1, 32'h8000_0108, 33'h1_8000_0104, 32'h0000_0021));
        vecs.push_back(mk(6'd0, 1, 32'hBFC0_0380, 1, 32'h8000_0000, 32'h03E0_0008, 1, 32'h8000_010C, 33'h1_8000_0108, 32'h03E0_0008));
        vecs.push_back(mk(6'd0, 0, 0, 0, 0, 32'h2222_2222, 1, 32'hBFC0_0380, 33'h0,           32'h0));
        vecs.push_back(mk(6'd0, 0, 0, 0, 0, 32'h4200_0018, 1, 32'hBFC0_0384, 33'h1_BFC0_0380, 32'h4200_0018));
        vecs.push_back(mk(6'd7, 0, 0, 0, 0, 32'h240A_0003, 0, 32'hBFC0_0388, 33'h1_BFC0_0384, 32'h240A_0003));
        vecs.push_back(mk(6'd7, 1, 32'hBFC0_0380, 0, 0, 32'h4444_4444, 0, 32'hBFC0_0388, 33'h1_BFC0_0384, 32'h240A_0003));
        vecs.push_back(mk(6'd0, 0, 0, 0, 0, 32'h3333_3333, 1, 32'hBFC0_0380, 33'h0,           32'h0));
        vecs.push_back(mk(6'd0, 0, 0, 1, 32'hFFFF_FFFC, 32'h4200_0018, 1, 32'hBFC0_0384, 33'h1_BFC0_0380, 32'h4200_0018));
        vecs.push_back(mk(6'd0, 0, 0, 0, 0, 32'h6666_6666, 1, 32'hFFFF_FFFC, 33'h0,           32'h0));
        vecs.push_back(mk(6'd0, 0, 0, 0, 0, 32'h1234_5678, 1, 32'h0000_0000, 33'h1_FFFF_FFFC, 32'h1234_5678));
        vecs.push_back(mk(6'd0, 0, 0, 0, 0, 32'h9ABC_DEF0, 1, 32'h0000_0004, 33'h1_0000_0000, 32'h9ABC_DEF0));

        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset.en",   {32'd0, inst_sram_en}, 33'd0);
        check("reset.addr", {1'b0, inst_sram_addr}, {1'b0, 32'hBFC0_0000});
        check("reset.bus",  ic_to_id_bus, 33'd0);
        check("reset.inst", {1'b0, ic_inst}, 33'd0);
        check("reset.cnt",  {1'b0, fetch_cnt}, 33'd0);

        @(posedge clk);
        #1 rst = 1'b1;
        for (int i = 0; i < vecs.size(); i++) begin
            stall = vecs[i].stall;  flush = vecs[i].flush;  new_pc = vecs[i].new_pc;
            br_e  = vecs[i].br_e;   br_addr = vecs[i].br_addr;
            inst_sram_rdata = vecs[i].rdata;
            exp_q.push_back(vecs[i]);
            @(negedge clk);
            e = exp_q.pop_front();
            check($sformatf("v%0d.en", i),   {32'd0, inst_sram_en},     {32'd0, e.exp_en});
            check($sformatf("v%0d.addr", i), {1'b0, inst_sram_addr},    {1'b0, e.exp_addr});
            check($sformatf("v%0d.bus", i),  ic_to_id_bus,              e.exp_bus);
            check($sformatf("v%0d.inst", i), {1'b0, ic_inst},           {1'b0, e.exp_inst});
            @(posedge clk);
            #1;
        end

        // Reset asserted mid-stall with the skid buffer holding data.
        stall = 6'd3; flush = 1'b0; br_e = 1'b0;
        inst_sram_rdata = 32'h55AA_55AA;
        @(negedge clk);
        check("rststall.inst0", {1'b0, ic_inst}, {1'b0, 32'h55AA_55AA});
        @(posedge clk);
        #1 inst_sram_rdata = 32'h0BAD_F00D;
        @(negedge clk);
        check("rststall.buffered", {1'b0, ic_inst}, {1'b0, 32'h55AA_55AA});
        #1 rst = 1'b0;
        #1;
        check("rststall.en",   {32'd0, inst_sram_en}, 33'd0);
        check("rststall.addr", {1'b0, inst_sram_addr}, {1'b0, 32'hBFC0_0000});
        check("rststall.bus",  ic_to_id_bus, 33'd0);
        check("rststall.inst", {1'b0, ic_inst}, 33'd0);
        check("rststall.cnt",  {1'b0, fetch_cnt}, 33'd0);

        @(posedge clk);
        #1 begin stall = 6'd0; rst = 1'b1; end
        repeat (3) @(posedge clk);
        @(negedge clk);
`ifdef IF_PERF_CNT_EN
        exp_cnt = 32'd3;
`else
        exp_cnt = 32'd0;
`endif
        check("release.cnt",  {1'b0, fetch_cnt}, {1'b0, exp_cnt});
        check("release.addr", {1'b0, inst_sram_addr}, {1'b0, 32'hBFC0_000C});
        check("release.bus",  ic_to_id_bus, 33'h1_BFC0_0008);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
